// File: rtl/alu_pkg.sv
// Shared opcodes and default datapath width for the MiniSRC execute stage.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;

endpackage

// File: rtl/fast_adder_cla.sv
// Carry-lookahead adder: 4-bit groups, with group generate/propagate combined by a second lookahead level.
module fast_adder_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] carry;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_c;
  logic             gg;
  logic             gp;
  logic             acc;

  always_comb begin
    p     = x_in ^ y_in;
    g     = x_in & y_in;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    carry = '0;
    gg    = 1'b0;
    gp    = 1'b1;
    acc   = 1'b0;

    for (int gi = 0; gi < NGRP; gi++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int b = 0; b < 4; b++) begin
        gg = g[gi*4+b] | (p[gi*4+b] & gg);
        gp = gp & p[gi*4+b];
      end
      grp_g[gi] = gg;
      grp_p[gi] = gp;
    end

    // Group carry-ins come straight from group G/P and c_in, not from group sums.
    for (int gi = 0; gi < NGRP; gi++) begin
      acc = c_in;
      for (int k = 0; k < gi; k++) begin
        acc = grp_g[k] | (grp_p[k] & acc);
      end
      grp_c[gi] = acc;
    end

    for (int gi = 0; gi < NGRP; gi++) begin
      acc = grp_c[gi];
      for (int b = 0; b < 4; b++) begin
        carry[gi*4+b] = acc;
        acc = g[gi*4+b] | (p[gi*4+b] & acc);
      end
    end

    sum_out = p ^ carry;
    c_out   = grp_g[NGRP-1] | (grp_p[NGRP-1] & grp_c[NGRP-1]);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered MiniSRC execute stage (B-mux, CLA add/sub, logic ops, optional mul/div into RZ0/RZ1).
// Define ALU_MULDIV_EN to build the signed multiplier and divider; otherwise DIV/MUL act as reserved codes.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [WIDTH-1:0] iImm,
  input  logic             iBSel,
  input  logic [3:0]       iCtrl,
  output logic [WIDTH-1:0] oC0,
  output logic [WIDTH-1:0] oC1,
  output logic             oZero,
  output logic             oCarry
);

  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] nxt_c0;
  logic [WIDTH-1:0] nxt_c1;
  logic             nxt_carry;

  assign bop     = iBSel ? iImm : iB;
  assign add_cin = (iCtrl == ALU_SUB);
  assign add_y   = add_cin ? ~bop : bop;

  fast_adder_cla #(.WIDTH(WIDTH)) u_cla (
    .x_in    (iA),
    .y_in    (add_y),
    .c_in    (add_cin),
    .sum_out (add_sum),
    .c_out   (add_cout)
  );

`ifdef ALU_MULDIV_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] mul_prod;
  logic signed [WIDTH-1:0]   div_q;
  logic signed [WIDTH-1:0]   div_r;
  logic                      div_special;

  // Zero divisor and MIN/-1 are resolved explicitly, so the divider never sees them.
  always_comb begin
    mul_prod    = $signed(iA) * $signed(bop);
    div_special = (bop == '0) || ((iA == MIN_NEG) && (bop == '1));
    div_q       = '0;
    div_r       = '0;
    if (!div_special) begin
      div_q = $signed(iA) / $signed(bop);
      div_r = $signed(iA) % $signed(bop);
    end
  end
`endif

  always_comb begin
    nxt_c0    = '0;
    nxt_c1    = '0;
    nxt_carry = 1'b0;
    case (iCtrl)
      ALU_ADD, ALU_SUB: begin
        nxt_c0    = add_sum;
        nxt_carry = add_cout;
      end
      ALU_OR:  nxt_c0 = iA | bop;
      ALU_AND: nxt_c0 = iA & bop;
`ifdef ALU_MULDIV_EN
      ALU_DIV: begin
        if (bop == '0) begin
          nxt_c0 = '1;
          nxt_c1 = iA;
        end else if (div_special) begin
          nxt_c0 = MIN_NEG;
        end else begin
          nxt_c0 = div_q;
          nxt_c1 = div_r;
        end
      end
      ALU_MUL: {nxt_c1, nxt_c0} = mul_prod;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oC0    <= '0;
      oC1    <= '0;
      oZero  <= 1'b1;
      oCarry <= 1'b0;
    end else if (iEn) begin
      oC0    <= nxt_c0;
      oC1    <= nxt_c1;
      oZero  <= (nxt_c0 == '0);
      oCarry <= nxt_carry;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus random traffic against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEn;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [31:0] iImm;
  logic        iBSel;
  logic [3:0]  iCtrl;
  logic [31:0] oC0;
  logic [31:0] oC1;
  logic        oZero;
  logic        oCarry;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_c0;
  logic [31:0] m_c1;
  logic        m_zero;
  logic        m_carry;

  always #5 iClk = ~iClk;

  alu_exec_stage dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (iEn),
    .iA     (iA),
    .iB     (iB),
    .iImm   (iImm),
    .iBSel  (iBSel),
    .iCtrl  (iCtrl),
    .oC0    (oC0),
    .oC1    (oC1),
    .oZero  (oZero),
    .oCarry (oCarry)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic void ref_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] c0, output logic [31:0] c1, output logic cy);
    longint sa, sb, q, r, prod;
    logic [32:0] wide;
    c0 = 0; c1 = 0; cy = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctrl)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        c0 = wide[31:0];
        cy = wide[32];
      end
      4'd1: begin
        c0 = a - b;
        cy = (a >= b);
      end
      4'd2: c0 = a | b;
      4'd3: c0 = a & b;
`ifdef ALU_MULDIV_EN
      4'd4: begin
        if (b == 0) begin
          c0 = 32'hFFFF_FFFF;
          c1 = a;
        end else begin
          q = sa / sb;
          r = sa % sb;
          c0 = q[31:0];
          c1 = r[31:0];
        end
      end
      4'd5: begin
        prod = sa * sb;
        c0 = prod[31:0];
        c1 = prod[63:32];
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic step(input logic rst, input logic en, input logic [3:0] ctrl,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic bsel);
    logic [31:0] c0, c1;
    logic cy;
    @(negedge iClk);
    iRst = rst; iEn = en; iCtrl = ctrl; iA = a; iB = b; iImm = imm; iBSel = bsel;
    @(posedge iClk);
    #1;
    if (rst) begin
      m_c0 = 0; m_c1 = 0; m_zero = 1; m_carry = 0;
    end else if (en) begin
      ref_op(ctrl, a, bsel ? imm : b, c0, c1, cy);
      m_c0 = c0; m_c1 = c1; m_carry = cy; m_zero = (c0 == 0);
    end
    check_eq("c0", {32'd0, oC0}, {32'd0, m_c0});
    check_eq("c1", {32'd0, oC1}, {32'd0, m_c1});
    check_eq("zero", {63'd0, oZero}, {63'd0, m_zero});
    check_eq("carry", {63'd0, oCarry}, {63'd0, m_carry});
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 15);
      2: return 32'd0 - $urandom_range(1, 16);
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_0000;
          1: return 32'h0000_0001;
          2: return 32'hFFFF_FFFF;
          3: return 32'h8000_0000;
          default: return 32'h7FFF_FFFF;
        endcase
      end
    endcase
  endfunction

  initial begin
    logic [3:0] rc;
    iRst = 1; iEn = 0; iA = 0; iB = 0; iImm = 0; iBSel = 0; iCtrl = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h1111, 32'h2222, 0, 0);
    check_eq("rst_c0", {32'd0, oC0}, 64'd0);
    check_eq("rst_zero", {63'd0, oZero}, 64'd1);
    step(0, 0, 0, 32'hDEAD_BEEF, 32'h1234, 32'h55, 1);
    check_eq("hold_c0", {32'd0, oC0}, 64'd0);

    step(0, 1, 4'b0000, 32'hFFFF_FFFF, 32'd1, 0, 0);
    check_eq("add_wrap_c0", {32'd0, oC0}, 64'd0);
    check_eq("add_wrap_zero", {63'd0, oZero}, 64'd1);
    check_eq("add_wrap_carry", {63'd0, oCarry}, 64'd1);
    step(0, 1, 4'b0001, 32'd5, 32'd7, 0, 0);
    check_eq("sub_borrow_c0", {32'd0, oC0}, {32'd0, 32'hFFFF_FFFE});
    check_eq("sub_borrow_carry", {63'd0, oCarry}, 64'd0);
    step(0, 1, 4'b0001, 32'd7, 32'd5, 0, 0);
    check_eq("sub_c0", {32'd0, oC0}, 64'd2);
    check_eq("sub_carry", {63'd0, oCarry}, 64'd1);

    step(0, 1, 4'b0010, 32'h1234_5678, 32'hF0F0_F0F0, 32'h0000_FFFF, 1);
    check_eq("or_imm", {32'd0, oC0}, {32'd0, 32'h1234_FFFF});
    step(0, 1, 4'b0011, 32'h1234_5678, 32'hF0F0_F0F0, 32'h0000_FFFF, 0);
    check_eq("and_reg", {32'd0, oC0}, {32'd0, 32'h1030_5070});

    step(0, 1, 4'b0101, 32'hFFFF_FFFD, 32'd7, 0, 0);
`ifdef ALU_MULDIV_EN
    check_eq("mul_neg", {oC1, oC0}, 64'hFFFF_FFFF_FFFF_FFEB);
`else
    check_eq("mul_reserved", {oC1, oC0}, 64'd0);
`endif
    step(0, 1, 4'b0101, 32'h0001_0000, 32'h0001_0000, 0, 0);
`ifdef ALU_MULDIV_EN
    check_eq("mul_hi", {oC1, oC0}, 64'h0000_0001_0000_0000);
`endif
    check_eq("mul_hi_zero", {63'd0, oZero}, 64'd1);
    step(0, 1, 4'b0100, 32'hFFFF_FFF9, 32'd2, 0, 0);
`ifdef ALU_MULDIV_EN
    check_eq("div_neg", {oC1, oC0}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    check_eq("div_reserved", {oC1, oC0}, 64'd0);
`endif
    step(0, 1, 4'b0100, 32'd9, 32'd0, 0, 0);
`ifdef ALU_MULDIV_EN
    check_eq("div_by_zero", {oC1, oC0}, 64'h0000_0009_FFFF_FFFF);
`endif
    step(0, 1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
`ifdef ALU_MULDIV_EN
    check_eq("div_ovf", {oC1, oC0}, 64'h0000_0000_8000_0000);
`endif

    step(0, 1, 4'b0000, 32'd3, 32'd4, 0, 0);
    step(0, 1, 4'b1010, 32'hABCD, 32'h1234, 0, 0);
    check_eq("reserved", {oC1, oC0}, 64'd0);
    step(0, 1, 4'b0000, 32'd3, 32'd4, 0, 0);
    step(1, 1, 4'b0000, 32'd1, 32'd1, 0, 0);
    check_eq("rst_prio_c0", {32'd0, oC0}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rc,
           rand_val(), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage of the MiniSRC datapath. It sits between the RA/RB operand registers and the Y-mux. It selects operand B (register or immediate), computes one of six ALU operations through a carry-lookahead adder and a multiply/divide unit, and captures the results in its RZ0/RZ1 output registers. The result is available to the Y-mux one cycle after the operation is enabled.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is required to work.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iEn  in  1  capture enable for result registers (RZ enable).
- iA  in  32  operand A (RA).
- iB  in  32  register operand B (RB).
- iImm  in  32  immediate operand B, already sign-extended by the caller.
- iBSel  in  1  B-mux select: 0 = iB, 1 = iImm.
- iCtrl  in  4  operation code.
- oC0  out  32  registered primary result (RZ0 / LO / quotient).
- oC1  out  32  registered secondary result (RZ1 / HI / remainder).
- oZero  out  1  registered flag: 1 when captured oC0 == 0.
- oCarry  out  1  registered adder carry-out of the last add/sub; 0 for other ops.

## Operation
- Operand B is Bop = iBSel ? iImm : iB.
- 0000 ADD: C0 = A + Bop (mod 2^32), computed by the CLA with cin = 0; C1 = 0; carry = adder cout.
- 0001 SUB: C0 = A + ~Bop + 1 on the same CLA, with cin = 1; C1 = 0; carry = cout, meaning 1 when there is no borrow.
- 0010 OR: C0 = A | Bop; C1 = 0.
- 0011 AND: C0 = A & Bop; C1 = 0.
- 0100 DIV: signed division truncating toward zero. C0 = quotient; C1 = remainder, and the remainder takes the sign of A.
  - Bop == 0: C0 = 32'hFFFF_FFFF, C1 = A.
  - A = 32'h8000_0000 with Bop = -1: C0 = 32'h8000_0000, C1 = 0.
- 0101 MUL: signed 32x32 -> 64 product; C0 = product[31:0], C1 = product[63:32].
- 0110–1111: C0 = 0, C1 = 0, carry = 0. These codes are reserved.
- Zero flag is computed from the C0 value being captured.
- There is no overflow flag and no exception output.

## Timing
- Combinational path: iA/iB/iImm/iBSel/iCtrl -> next-state of oC0/oC1/oZero/oCarry.
- Registers load on a rising iClk edge when iEn = 1; otherwise they hold their value.
- Latency is 1 cycle for every operation, including MUL and DIV. There is no busy or stall signal.
- Reset: when iRst = 1 at a rising edge, oC0 = 0, oC1 = 0, oZero = 1, oCarry = 0.
- iRst has priority over iEn. If a reset arrives in the same cycle as an enable, the enabled result is discarded.
- Inputs may change every cycle. Only the values present at the enabled edge matter.

## Configuration
- ALU_MULDIV_EN defined: MUL and DIV operate as specified above.
- ALU_MULDIV_EN undefined: codes 0100 and 0101 behave as reserved codes (C0 = C1 = 0, oZero = 1 when captured). No multiplier or divider logic is synthesized.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: ALU_ADD = 4'b0000, ALU_SUB, ALU_OR, ALU_AND, ALU_DIV, ALU_MUL;
  - the WIDTH default.
- Sub-module fast_adder_cla provides the adder:
  - ports x_in, y_in, c_in, sum_out, c_out;
  - 4-bit lookahead groups with group-level lookahead, producing a 32-bit sum;
  - it is the only adder used for ADD/SUB.
- The B-mux is an inline 2:1, 32-bit select. No separate module is required.

## Test plan
- Reset: hold iRst = 1 for 2 cycles -> oC0 = 0, oC1 = 0, oZero = 1, oCarry = 0. Then set iEn = 0 with arbitrary inputs -> outputs unchanged.
- ADD/SUB with carry:
  - A = 32'hFFFF_FFFF, B = 1, ADD -> C0 = 0, oZero = 1, oCarry = 1.
  - A = 5, B = 7, SUB -> C0 = 32'hFFFF_FFFE, oCarry = 0.
  - A = 7, B = 5, SUB -> C0 = 2, oCarry = 1.
- B-mux and logic: iB = 32'hF0F0_F0F0, iImm = 32'h0000_FFFF, A = 32'h1234_5678.
  - OR with iBSel = 1 -> 32'h1234_FFFF.
  - AND with iBSel = 0 -> 32'h1030_5070.
- MUL: A = -3, B = 7 -> C0 = 32'hFFFF_FFEB, C1 = 32'hFFFF_FFFF. A = 32'h0001_0000, B = 32'h0001_0000 -> C0 = 0, C1 = 1, oZero = 1.
- DIV:
  - A = -7, B = 2 -> C0 = -3, C1 = -1.
  - A = 9, B = 0 -> C0 = 32'hFFFF_FFFF, C1 = 9.
  - A = 32'h8000_0000, B = -1 -> C0 = 32'h8000_0000, C1 = 0.
- Reserved and reset priority:
  - iCtrl = 4'b1010 -> C0 = C1 = 0.
  - iRst = 1 with iEn = 1 and an ADD of 1 + 1 -> oC0 = 0.
